vga_sync_monitor: RTL and testbench

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

---
 rtl/vga_sync_monitor.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// vga_sync_monitor
//
// Passive monitor for a VGA-style pixel stream in the pixel-clock domain. It
// measures the active line width and frame height, and locks once the timing
// repeats correctly for LOCK_FRAMES consecutive frames. It also samples the
// colour of one chosen pixel every frame.
//
// Parameters
//   H_ACTIVE    expected active pixels per line
//   V_ACTIVE    expected active lines per frame
//   LOCK_FRAMES consecutive good frames needed to assert locked
//   TIMEOUT     clk cycles without an hsync falling edge before loss of signal
//
// Ports
//   clk              pixel clock, one pixel per cycle
//   reset            asynchronous, active-low reset
//   vga_hs, vga_vs   horizontal / vertical sync, active-low
//   vga_blank_n      1 = active pixel
//   red/green/blue   pixel colour, 8 bits each
//   probeX, probeY   coordinate to capture; latched once per frame
//   locked           timing stable (registered, glitch-free)
//   meas_width       active pixels in the last completed line
//   meas_height      active lines in the last completed frame
//   frame_done       one-cycle pulse per vsync falling edge
//   frame_count      completed frames, wraps 255 -> 0
//   line_err         sticky within a frame: some line width != H_ACTIVE
//   probe_rgb        captured {red,green,blue}, held until the next capture
//   probe_valid      one-cycle pulse on capture
//
// Timing: every input is registered once, and edges are found by comparing
// that register with its previous value. All results update on the clock
// edge after detection, which is two cycles after the pin changes.
// -----------------------------------------------------------------------------
module vga_sync_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic [9:0]  probeX,
  input  logic [9:0]  probeY,
  output logic        locked,
  output logic [9:0]  meas_width,
  output logic [9:0]  meas_height,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        line_err,
  output logic [23:0] probe_rgb,
  output logic        probe_valid
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [9:0]    H_EXP     = 10'(H_ACTIVE);
  localparam logic [9:0]    V_EXP     = 10'(V_ACTIVE);
  localparam logic [9:0]    CNT_MAX   = 10'h3FF;
  localparam logic [GW-1:0] GOOD_NEED = GW'(LOCK_FRAMES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input registers and edge detection
  // ---------------------------------------------------------------------------
  logic        hs_r, vs_r, blank_r;
  logic        hs_d, vs_d;
  logic [23:0] rgb_r;
  logic [9:0]  probe_x_r, probe_y_r;
  logic        in_valid;   // registered inputs now reflect real pin values

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge and the order of the
  // statements inside the block never changes the result.
  // The sync registers reset to 0, not to the idle level 1. Then a sync pin
  // that is already low at reset release cannot look like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
      blank_r   <= 1'b0;
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      rgb_r     <= '0;
      probe_x_r <= '0;
      probe_y_r <= '0;
      in_valid  <= 1'b0;
    end else begin
      hs_r      <= vga_hs;
      vs_r      <= vga_vs;
      blank_r   <= vga_blank_n;
      hs_d      <= hs_r;
      vs_d      <= vs_r;
      rgb_r     <= {red, green, blue};
      probe_x_r <= probeX;
      probe_y_r <= probeY;
      in_valid  <= 1'b1;
    end
  end

  logic hs_fall, vs_fall;
  assign hs_fall = hs_d & ~hs_r;
  assign vs_fall = vs_d & ~vs_r;

  // ---------------------------------------------------------------------------
  // Shared combinational terms
  // ---------------------------------------------------------------------------
  logic [9:0]    x, y;
  logic [TW-1:0] to_cnt;
  logic          captured;
  logic          shadow_loaded;
  logic [9:0]    shadow_x, shadow_y;
  logic [GW-1:0] gcnt;
  state_t        state;

  logic       line_close;   // hs fall that ends a line with active pixels
  logic [9:0] y_inc;
  logic [9:0] y_closed;     // line count once any line closing this cycle is added
  logic       err_closed;   // line_err once any line closing this cycle is added
  logic       frame_good;
  logic       timeout_hit;  // the idle counter reaches TIMEOUT on this edge
  logic       probe_hit;

  assign line_close = hs_fall && (x != 10'd0);
  assign y_inc      = (y == CNT_MAX) ? y : y + 10'd1;

  // A line that closes in the same cycle as the vs fall still belongs to the
  // frame that is ending, so the frame logic sees these post-line values.
  assign y_closed   = line_close ? y_inc : y;
  assign err_closed = line_err | (line_close && (x != H_EXP));
  assign frame_good = (y_closed == V_EXP) && !err_closed;

  assign timeout_hit = !hs_fall && (to_cnt == TO_LAST);

  // Uses the pre-increment coordinates of the current active pixel.
  assign probe_hit = blank_r && !captured &&
                     (x == shadow_x) && (y == shadow_y);

  // ---------------------------------------------------------------------------
  // Pixel / line / frame counters and measurements
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      to_cnt      <= '0;
      meas_width  <= '0;
      meas_height <= '0;
      line_err    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= vs_fall;

      // Active pixel counter within the current line.
      if (timeout_hit || hs_fall) begin
        x <= '0;
      end else if (blank_r && (x != CNT_MAX)) begin
        x <= x + 10'd1;
      end

      // Line close: blank lines (x == 0) leave every measurement alone.
      if (line_close) begin
        meas_width <= x;
      end

      // Frame close comes after line close, using the combined values.
      if (vs_fall) begin
        meas_height <= y_closed;
        frame_count <= frame_count + 8'd1;
        line_err    <= 1'b0;
      end else if (line_close && (x != H_EXP)) begin
        line_err <= 1'b1;
      end

      if (timeout_hit || vs_fall) begin
        y <= '0;
      end else if (line_close) begin
        y <= y_inc;
      end

      // Cycles since the last hs fall, saturating at TIMEOUT.
      if (hs_fall) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock state machine
  // ---------------------------------------------------------------------------
  // The first vs fall after SEARCH only marks where a frame starts. The frame
  // before it was partial, so it never counts as good.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= SEARCH;
      gcnt   <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state <= MEASURE;
            gcnt  <= '0;
          end
        end
        MEASURE: begin
          if (vs_fall) begin
            if (!frame_good) begin
              gcnt <= '0;
            end else if (gcnt + 1'b1 == GOOD_NEED) begin
              state  <= LOCKED;
              gcnt   <= GOOD_NEED;
              locked <= 1'b1;
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (vs_fall && !frame_good) begin
            state  <= MEASURE;
            gcnt   <= '0;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          gcnt   <= '0;
          locked <= 1'b0;
        end
      endcase

      // Loss of signal overrides whatever the frame logic decided.
      if (timeout_hit) begin
        state  <= SEARCH;
        gcnt   <= '0;
        locked <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel probe
  // ---------------------------------------------------------------------------
  // The probe coordinate is copied into a shadow register once, just after
  // reset release (when the input registers first hold real pin values). It
  // is copied again at each vs fall. Changes to probeX/probeY during a frame
  // therefore only take effect in the next frame.
  // A coordinate outside the measured frame just never matches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_x      <= '0;
      shadow_y      <= '0;
      shadow_loaded <= 1'b0;
      captured      <= 1'b0;
      probe_rgb     <= '0;
      probe_valid   <= 1'b0;
    end else begin
      if (vs_fall || (in_valid && !shadow_loaded)) begin
        shadow_x <= probe_x_r;
        shadow_y <= probe_y_r;
      end
      if (in_valid) begin
        shadow_loaded <= 1'b1;
      end

      probe_valid <= probe_hit;
      if (probe_hit) begin
        probe_rgb <= rgb_r;
      end

      if (vs_fall || timeout_hit) begin
        captured <= 1'b0;
      end else if (probe_hit) begin
        captured <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_monitor
//
// Self-checking bench for vga_sync_monitor. It uses a scaled-down raster:
// 16x24 active pixels, 20 clocks per line, and 4 blank lines per frame
// (1 front porch, 2 vsync, 1 back porch). This keeps whole-frame scenarios
// short.
// A table of frame records drives the lock and unlock sequence. Random
// frames are then checked against a frame-level model. Hand-written
// sequences cover the timeout, asynchronous reset and frame_count wrap.
// -----------------------------------------------------------------------------
module tb_vga_sync_monitor;

  localparam int H_ACT    = 16;
  localparam int V_ACT    = 24;
  localparam int LOCK_N   = 2;
  localparam int TO       = 1023;
  localparam int LINE_LEN = 20;
  localparam int HS_START = 17;   // hsync low on pixels 17..18
  localparam int HS_LEN   = 2;
  localparam int VS_LEN   = 2 * LINE_LEN;
  localparam int PX       = 10;
  localparam int PY       = 20;
  localparam logic [23:0] PCOL = 24'hA5C3E1;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  red, green, blue;
  logic [9:0]  probeX, probeY;
  logic        locked;
  logic [9:0]  meas_width, meas_height;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        line_err;
  logic [23:0] probe_rgb;
  logic        probe_valid;

  vga_sync_monitor #(
    .H_ACTIVE   (H_ACT),
    .V_ACTIVE   (V_ACT),
    .LOCK_FRAMES(LOCK_N),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .probeX     (probeX),
    .probeY     (probeY),
    .locked     (locked),
    .meas_width (meas_width),
    .meas_height(meas_height),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .line_err   (line_err),
    .probe_rgb  (probe_rgb),
    .probe_valid(probe_valid)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse counters sampled on the falling edge, away from the active edge.
  int fd_seen = 0;
  int pv_seen = 0;
  always @(negedge clk) begin
    if (frame_done === 1'b1)  fd_seen++;
    if (probe_valid === 1'b1) pv_seen++;
  end

  // Expected state carried across frames.
  int          fc_exp  = 0;
  logic [23:0] rgb_exp = '0;
  int          line_w[0:31];

  // One pixel clock: the pins change 1 time unit after the rising edge.
  task automatic drive(input logic hs, input logic vs, input logic blank,
                       input logic [23:0] rgb);
    @(posedge clk);
    #1;
    vga_hs      = hs;
    vga_vs      = vs;
    vga_blank_n = blank;
    {red, green, blue} = rgb;
  endtask

  // One frame. Lines 0..n_lines-1 use line_w[] active pixels. vsync falls
  // at the start of line n_lines+1, or together with the last line's hsync
  // fall when aligned is set. line_err is sampled just as vsync falls,
  // because the DUT has not yet seen that edge.
  task automatic run_frame(input int n_lines, input bit aligned,
                           input bit rand_rgb, input bit wiggle,
                           input logic [23:0] pcol, input int stop_at,
                           output logic err_mid);
    int total, vs_start, lim;
    logic [23:0] c;
    logic hs, vs, bl;
    total    = (n_lines + 4) * LINE_LEN;
    vs_start = aligned ? (n_lines - 1) * LINE_LEN + HS_START
                       : (n_lines + 1) * LINE_LEN;
    lim      = (stop_at < 0) ? total : stop_at;
    err_mid  = 1'b0;
    for (int i = 0; i < lim; i++) begin
      int l, p;
      l  = i / LINE_LEN;
      p  = i % LINE_LEN;
      hs = !(p >= HS_START && p < HS_START + HS_LEN);
      vs = !(i >= vs_start && i < vs_start + VS_LEN);
      bl = (l < n_lines) && (p < line_w[l]);
      c  = rand_rgb ? 24'($urandom) : 24'h0;
      if (l == PY && p == PX) c = pcol;
      if (wiggle && i == 5 * LINE_LEN) probeX = 10'd3;
      if (wiggle && i == n_lines * LINE_LEN) probeX = 10'(PX);
      drive(hs, vs, bl, c);
      if (i == vs_start) err_mid = line_err;
    end
  endtask

  // Run one full frame, then compare every frame-level output.
  task automatic frame_and_check(input string tag, input int n_lines,
                                 input bit aligned, input bit rand_rgb,
                                 input bit wiggle, input logic [23:0] pcol,
                                 input bit exp_locked, input int exp_h,
                                 input int exp_w, input bit exp_err,
                                 input bit exp_pv);
    int fd0, pv0;
    logic err_mid;
    fd0 = fd_seen;
    pv0 = pv_seen;
    run_frame(n_lines, aligned, rand_rgb, wiggle, pcol, -1, err_mid);
    fc_exp = (fc_exp + 1) % 256;
    if (exp_pv) rgb_exp = pcol;
    check({tag, " frame_done pulses"}, fd_seen - fd0, 1);
    check({tag, " locked"},      32'(locked),      32'(exp_locked));
    check({tag, " meas_height"}, 32'(meas_height), exp_h);
    check({tag, " meas_width"},  32'(meas_width),  exp_w);
    check({tag, " line_err mid"}, 32'(err_mid),    32'(exp_err));
    check({tag, " line_err cleared"}, 32'(line_err), 0);
    check({tag, " frame_count"}, 32'(frame_count), fc_exp);
    check({tag, " probe_valid pulses"}, pv_seen - pv0, exp_pv ? 1 : 0);
    check({tag, " probe_rgb"},   32'(probe_rgb),   32'(rgb_exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " locked"},      32'(locked),      0);
    check({tag, " meas_width"},  32'(meas_width),  0);
    check({tag, " meas_height"}, 32'(meas_height), 0);
    check({tag, " frame_done"},  32'(frame_done),  0);
    check({tag, " frame_count"}, 32'(frame_count), 0);
    check({tag, " line_err"},    32'(line_err),    0);
    check({tag, " probe_rgb"},   32'(probe_rgb),   0);
    check({tag, " probe_valid"}, 32'(probe_valid), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Table of frame scenarios: stimulus plus hand-derived expectations
  // ---------------------------------------------------------------------------
  typedef struct {
    int n_lines;
    int bad_line;    // -1: every line is H_ACT wide
    int bad_w;
    bit aligned;     // vs falls in the same cycle as the last line's hs
    bit wiggle;      // probeX moved away and back during the frame
    bit exp_locked;
    int exp_h;
    int exp_w;
    bit exp_err;
  } row_t;

  row_t rows[14];

  // Random-frame model state: after the first vs fall from SEARCH, count
  // the run of consecutive good frames; lock once the run reaches LOCK_N.
  bit synced;
  int streak;

  initial begin
    logic err_dummy;
    int   k, fd0;

    rows[0]  = '{24, -1, 16, 1'b0, 1'b0, 1'b0, 24, 16, 1'b0}; // SEARCH -> MEASURE
    rows[1]  = '{24, -1, 16, 1'b0, 1'b0, 1'b0, 24, 16, 1'b0}; // 1 good
    rows[2]  = '{24, -1, 16, 1'b0, 1'b0, 1'b1, 24, 16, 1'b0}; // 2 good -> lock
    rows[3]  = '{24, -1, 16, 1'b0, 1'b1, 1'b1, 24, 16, 1'b0}; // probe moved mid-frame
    rows[4]  = '{24,  5, 15, 1'b0, 1'b0, 1'b0, 24, 16, 1'b1}; // 15-wide line
    rows[5]  = '{24, -1, 16, 1'b0, 1'b0, 1'b0, 24, 16, 1'b0};
    rows[6]  = '{24, -1, 16, 1'b0, 1'b0, 1'b1, 24, 16, 1'b0}; // relock
    rows[7]  = '{24, 23, 15, 1'b0, 1'b0, 1'b0, 24, 15, 1'b1}; // last line short
    rows[8]  = '{24, -1, 16, 1'b0, 1'b0, 1'b0, 24, 16, 1'b0};
    rows[9]  = '{24, -1, 16, 1'b0, 1'b0, 1'b1, 24, 16, 1'b0};
    rows[10] = '{24, -1, 16, 1'b1, 1'b0, 1'b1, 24, 16, 1'b0}; // hs+vs same cycle
    rows[11] = '{23, -1, 16, 1'b0, 1'b0, 1'b0, 23, 16, 1'b0}; // short frame
    rows[12] = '{24, -1, 16, 1'b0, 1'b0, 1'b0, 24, 16, 1'b0};
    rows[13] = '{24, -1, 16, 1'b0, 1'b0, 1'b1, 24, 16, 1'b0};

    // ---- reset state ----
    reset       = 1'b0;
    vga_hs      = 1'b1;
    vga_vs      = 1'b1;
    vga_blank_n = 1'b0;
    {red, green, blue} = 24'h0;
    probeX      = 10'(PX);
    probeY      = 10'(PY);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // ---- table-driven lock / unlock / same-cycle edge scenarios ----
    for (int r = 0; r < 14; r++) begin
      for (int l = 0; l < 32; l++) line_w[l] = H_ACT;
      if (rows[r].bad_line >= 0) line_w[rows[r].bad_line] = rows[r].bad_w;
      frame_and_check($sformatf("row%0d", r), rows[r].n_lines,
                      rows[r].aligned, 1'b0, rows[r].wiggle, PCOL,
                      rows[r].exp_locked, rows[r].exp_h, rows[r].exp_w,
                      rows[r].exp_err, 1'b1);
    end

    // ---- loss of signal: one hs fall, then hs held high for 1100 cycles ----
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    for (int i = 1; i <= 1100; i++) begin
      drive(1'b1, 1'b1, 1'b0, 24'h0);
      if (i == TO + 1) check("timeout locked before", 32'(locked), 1);
      if (i == TO + 2) check("timeout locked after",  32'(locked), 0);
    end
    check("timeout meas_width held",  32'(meas_width),  H_ACT);
    check("timeout meas_height held", 32'(meas_height), V_ACT);
    for (int l = 0; l < 32; l++) line_w[l] = H_ACT;
    frame_and_check("relock1", V_ACT, 1'b0, 1'b0, 1'b0, PCOL, 1'b0, V_ACT, H_ACT, 1'b0, 1'b1);
    frame_and_check("relock2", V_ACT, 1'b0, 1'b0, 1'b0, PCOL, 1'b0, V_ACT, H_ACT, 1'b0, 1'b1);
    frame_and_check("relock3", V_ACT, 1'b0, 1'b0, 1'b0, PCOL, 1'b1, V_ACT, H_ACT, 1'b0, 1'b1);

    // ---- random frames against the frame-level model ----
    synced = 1'b1;
    streak = LOCK_N;
    for (int f = 0; f < 12; f++) begin
      int  r, n;
      bit  bad, good, exp_pv;
      logic [23:0] pc;
      r = int'($urandom_range(0, 7));
      n = (r == 0) ? 18 : (r == 1) ? 23 : (r == 2) ? 25 : V_ACT;
      bad = 1'b0;
      for (int l = 0; l < 32; l++) line_w[l] = 0;
      for (int l = 0; l < n; l++) begin
        line_w[l] = ($urandom_range(0, 9) == 0)
                      ? (($urandom_range(0, 1) == 0) ? 15 : 17) : H_ACT;
        if (line_w[l] != H_ACT) bad = 1'b1;
      end
      good = (n == V_ACT) && !bad;
      if (!synced) begin
        synced = 1'b1;
        streak = 0;
      end else if (good) begin
        streak++;
      end else begin
        streak = 0;
      end
      exp_pv = (n > PY) && (line_w[PY] > PX);
      pc     = 24'($urandom);
      frame_and_check($sformatf("rand%0d", f), n, 1'b0, 1'b1, 1'b0, pc,
                      streak >= LOCK_N, n, line_w[n - 1], bad, exp_pv);
    end

    // ---- asynchronous reset in the middle of a locked frame ----
    for (int l = 0; l < 32; l++) line_w[l] = H_ACT;
    frame_and_check("prelock1", V_ACT, 1'b0, 1'b0, 1'b0, PCOL,
                    (streak + 1) >= LOCK_N, V_ACT, H_ACT, 1'b0, 1'b1);
    streak++;
    frame_and_check("prelock2", V_ACT, 1'b0, 1'b0, 1'b0, PCOL, 1'b1,
                    V_ACT, H_ACT, 1'b0, 1'b1);
    run_frame(V_ACT, 1'b0, 1'b0, 1'b0, PCOL, 300, err_dummy);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    fc_exp  = 0;
    rgb_exp = '0;
    frame_and_check("rst lock1", V_ACT, 1'b0, 1'b0, 1'b0, PCOL, 1'b0, V_ACT, H_ACT, 1'b0, 1'b1);
    frame_and_check("rst lock2", V_ACT, 1'b0, 1'b0, 1'b0, PCOL, 1'b0, V_ACT, H_ACT, 1'b0, 1'b1);
    frame_and_check("rst lock3", V_ACT, 1'b0, 1'b0, 1'b0, PCOL, 1'b1, V_ACT, H_ACT, 1'b0, 1'b1);

    // ---- frame_count wrap: fast vsync toggling ----
    k   = 255 - fc_exp;
    fd0 = fd_seen;
    for (int i = 0; i < k; i++) begin
      drive(1'b1, 1'b1, 1'b0, 24'h0);
      drive(1'b1, 1'b0, 1'b0, 24'h0);
    end
    repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
    check("wrap count at 255", 32'(frame_count), 255);
    check("wrap frame_done pulses", fd_seen - fd0, k);
    drive(1'b1, 1'b0, 1'b0, 24'h0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
    check("wrap count to 0", 32'(frame_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
